// File: rtl/gcd_lcm_pkg.sv
// gcd_lcm_pkg: shared types and constants for the GCD/LCM coprocessor.
//   - state_t      : sequencer states
//   - arith_mode_t : operation select for the shared arithmetic unit
//   - REG_*        : word offsets inside the 16-byte bus window
//   - CTRL_*       : bit positions of the CTRL register
//   - OP_*         : operation encodings carried in CTRL.op
package gcd_lcm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ZCHK = 3'd1,
    GCD  = 3'd2,
    DIV  = 3'd3,
    MUL  = 3'd4,
    FIN  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ARITH_ADD  = 2'd0,  // a + b, carry on cout
    ARITH_SUB  = 2'd1,  // a - b
    ARITH_DIFF = 2'd2   // larger minus smaller
  } arith_mode_t;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_A    = 2'd1;
  localparam logic [1:0] REG_B    = 2'd2;
  localparam logic [1:0] REG_RES  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_OP    = 1;
  localparam int CTRL_CLR   = 2;

  localparam logic OP_GCD = 1'b0;
  localparam logic OP_LCM = 1'b1;

endpackage

// File: rtl/gcd_lcm_arith.sv
// gcd_lcm_arith: the single compare/subtract/add unit shared by every phase.
// Ports:
//   a, b  in  WIDTH  operands
//   mode  in         ARITH_ADD / ARITH_SUB / ARITH_DIFF
//   res   out WIDTH  result (low WIDTH bits)
//   cout  out 1      carry out of the add (bit WIDTH of the sum)
//   eq    out 1      a == b
//   gt    out 1      a > b
module gcd_lcm_arith
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  arith_mode_t      mode,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             eq,
  output logic             gt
);

  logic [WIDTH-1:0] op_l;
  logic [WIDTH-1:0] op_r;
  logic [WIDTH:0]   sum;

  always_comb begin
    eq   = (a == b);
    gt   = (a > b);
    op_l = a;
    op_r = b;
    // DIFF swaps the operands so one subtractor always yields a non-negative result
    if (mode == ARITH_DIFF && !gt) begin
      op_l = b;
      op_r = a;
    end
    if (mode == ARITH_ADD) sum = {1'b0, op_l} + {1'b0, op_r};
    else                   sum = {1'b0, op_l} - {1'b0, op_r};
    res  = sum[WIDTH-1:0];
    cout = sum[WIDTH];
  end

endmodule

// File: rtl/gcd_lcm_sequencer.sv
// gcd_lcm_sequencer: memory-mapped GCD/LCM coprocessor on the data bus.
// Software writes A, B and CTRL; the FSM runs subtractive GCD, then (LCM only)
// a repeated-subtraction divide A/g and a shift-add multiply q*B, all through
// one shared gcd_lcm_arith instance.
// Ports:
//   clk    in  1      core clock
//   reset  in  1      asynchronous active-high reset
//   sel    in  1      address decode hit for this block
//   addr   in  2      word offset: 0 CTRL/STATUS, 1 A, 2 B, 3 RESULT
//   we     in  1      write strobe
//   wdata  in  WIDTH  store data
//   rdata  out WIDTH  combinational read data (0 when sel is low)
//   irq    out 1      completion interrupt, only when GCD_LCM_IRQ_EN is defined
module gcd_lcm_sequencer
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
`ifdef GCD_LCM_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, a_next, b_reg, b_next, result_reg, result_next;
  logic [WIDTH-1:0]   x_reg, x_next, y_reg, y_next, q_reg, q_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               op_reg, op_next, done_reg, done_next, err_reg, err_next;
  logic               busy, wr_hit;
  logic [WIDTH-1:0]   q_inc;

  logic [WIDTH-1:0]   arith_a, arith_b, arith_res;
  arith_mode_t        arith_mode;
  logic               arith_cout, arith_eq, arith_gt;

  gcd_lcm_arith #(.WIDTH(WIDTH)) u_arith (
    .a    (arith_a),
    .b    (arith_b),
    .mode (arith_mode),
    .res  (arith_res),
    .cout (arith_cout),
    .eq   (arith_eq),
    .gt   (arith_gt)
  );

  assign busy   = (state_reg != IDLE);
  assign wr_hit = sel & we;
  assign q_inc  = q_reg + WIDTH'(1);

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    result_next = result_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    q_next      = q_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    done_next   = done_reg;
    err_next    = err_reg;
    arith_a     = x_reg;
    arith_b     = y_reg;
    arith_mode  = ARITH_DIFF;

    case (state_reg)
      IDLE: begin
        if (wr_hit && addr == REG_A) a_next = wdata;
        if (wr_hit && addr == REG_B) b_next = wdata;
        if (wr_hit && addr == REG_CTRL) begin
          if (wdata[CTRL_START]) begin
            op_next    = wdata[CTRL_OP];
            x_next     = a_reg;
            y_next     = b_reg;
            done_next  = 1'b0;
            err_next   = 1'b0;
            state_next = ZCHK;
          end else if (wdata[CTRL_CLR]) begin
            done_next = 1'b0;
            err_next  = 1'b0;
          end
        end
      end
      ZCHK: begin
        state_next = FIN;
        if (x_reg == '0 && y_reg == '0) begin
          result_next = '0;
          err_next    = 1'b1;
        end else if (op_reg == OP_LCM && (x_reg == '0 || y_reg == '0)) begin
          result_next = '0;
        end else if (x_reg == '0) begin
          result_next = y_reg;
        end else if (y_reg == '0) begin
          result_next = x_reg;
        end else begin
          state_next = GCD;
        end
      end
      GCD: begin
        if (arith_eq) begin
          if (op_reg == OP_GCD) begin
            result_next = x_reg;
            state_next  = FIN;
          end else begin
            // x keeps g; y becomes the working remainder of A for the divide
            y_next     = a_reg;
            q_next     = '0;
            state_next = DIV;
          end
        end else if (arith_gt) begin
          x_next = arith_res;
        end else begin
          y_next = arith_res;
        end
      end
      DIV: begin
        arith_a    = y_reg;
        arith_b    = x_reg;
        arith_mode = ARITH_SUB;
        y_next     = arith_res;
        q_next     = q_inc;
        // remainder equal to g means this subtraction leaves zero
        if (arith_eq) begin
          acc_next   = {{WIDTH{1'b0}}, q_inc};
          cnt_next   = '0;
          state_next = MUL;
        end
      end
      MUL: begin
        // multiplier q sits in acc low half and shifts out LSB-first
        arith_a    = acc_reg[2*WIDTH-1:WIDTH];
        arith_b    = b_reg;
        arith_mode = ARITH_ADD;
        if (acc_reg[0]) acc_next = {arith_cout, arith_res, acc_reg[WIDTH-1:1]};
        else            acc_next = {1'b0, acc_reg[2*WIDTH-1:1]};
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) begin
          result_next = acc_next[WIDTH-1:0];
          err_next    = |acc_next[2*WIDTH-1:WIDTH];
          state_next  = FIN;
        end
      end
      FIN: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      q_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      op_reg     <= OP_GCD;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      q_reg      <= q_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

`ifdef GCD_LCM_IRQ_EN
  logic irq_reg, irq_next;

  always_comb begin
    irq_next = irq_reg;
    if (sel && !we && addr == REG_CTRL) irq_next = 1'b0;
    if (!busy && wr_hit && addr == REG_CTRL && (wdata[CTRL_START] || wdata[CTRL_CLR]))
      irq_next = 1'b0;
    // completion takes priority over a simultaneous STATUS read
    if (state_reg == FIN) irq_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_reg <= 1'b0;
    else       irq_reg <= irq_next;
  end

  assign irq = irq_reg;
`endif

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        REG_CTRL: rdata[2:0] = {err_reg, done_reg, busy};
        REG_A:    rdata = a_reg;
        REG_B:    rdata = b_reg;
        default:  rdata = result_reg;
      endcase
    end
  end

endmodule
